// File: rtl/div_iter_param_if.sv
// EXE <-> iterative divider request/response bundle.
// master = EXE side (drives the request), slave = divider side.
interface div_iter_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start_i;
    logic               signed_i;
    logic               annul_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               dbz_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o, dbz_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o, dbz_o
    );
endinterface

// File: rtl/div_iter_param.sv
// Iterative restoring divider, one quotient bit per cycle; result = {remainder, quotient}.
// Optional macro DIV_EARLY_TERM_EN skips the leading-zero iterations of |dividend|.
module div_iter_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    div_iter_param_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_DBZ, S_CALC, S_FIX, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH:0]     r_rem;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_zdiv;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic               r_busy;
    logic               r_dbz;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_ready_d;
    logic               w_busy_d;
    logic               w_dbz_d;
    logic               w_load_res;
    logic [2*WIDTH-1:0] w_res_d;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH-1:0]   w_quo_init;
    logic [CW-1:0]      w_cnt_init;
    logic [WIDTH+1:0]   w_trial;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Operand magnitudes; unsigned mode passes the raw bits through.
    assign w_abs1 = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ?
                    WIDTH'(~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
    assign w_abs2 = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ?
                    WIDTH'(~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;
    assign w_div_zero = (bus.opdata2_i == '0);

`ifdef DIV_EARLY_TERM_EN
    logic [CW-1:0] w_lz;

    // Leading zeros of |dividend|; a zero dividend still needs one iteration.
    always_comb begin
        w_lz = CW'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (w_abs1[i]) w_lz = CW'(WIDTH - 1 - i);
        end
    end

    assign w_quo_init = w_abs1 << w_lz;
    assign w_cnt_init = CW'(WIDTH) - w_lz;
`else
    assign w_quo_init = w_abs1;
    assign w_cnt_init = CW'(WIDTH);
`endif

    // Trial subtract on the shifted partial remainder; MSB set means it went negative.
    assign w_trial = {1'b0, r_rem, r_quo[WIDTH-1]} - {2'b00, r_div};

    assign w_q_fix = r_neg_q ? WIDTH'(~r_quo + WIDTH'(1)) : r_quo;
    assign w_r_fix = r_neg_r ? WIDTH'(~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_ready_d  = 1'b0;
        w_dbz_d    = 1'b0;
        w_load_res = 1'b0;
        w_res_d    = r_result;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    w_accept = 1'b1;
                    w_next   = w_div_zero ? S_DBZ : S_CALC;
                end
            end
            S_DBZ: begin
                w_next     = S_DONE;
                w_load_res = 1'b1;
                w_res_d    = {r_quo, {WIDTH{1'b1}}};
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) w_next = S_FIX;
            end
            S_FIX: begin
                w_next     = S_DONE;
                w_load_res = 1'b1;
                w_res_d    = {w_r_fix, w_q_fix};
            end
            S_DONE: begin
                // Show the result at least once even if start_i already dropped.
                w_ready_d = bus.start_i || !r_ready;
                w_dbz_d   = w_ready_d && r_zdiv;
                if (!bus.start_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.annul_i && (r_state != S_IDLE)) begin
            w_next     = S_IDLE;
            w_ready_d  = 1'b0;
            w_dbz_d    = 1'b0;
            w_load_res = 1'b0;
        end
        w_busy_d = (w_next == S_DBZ) || (w_next == S_CALC) || (w_next == S_FIX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= w_ready_d;
            r_busy  <= w_busy_d;
            r_dbz   <= w_dbz_d;
            if (w_load_res) r_result <= w_res_d;
        end
    end

    // Operand capture at accept, then the shift/subtract iteration.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_quo   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zdiv  <= 1'b0;
        end else if (w_accept) begin
            r_zdiv  <= w_div_zero;
            r_rem   <= '0;
            r_div   <= w_abs2;
            r_neg_q <= bus.signed_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            r_neg_r <= bus.signed_i && bus.opdata1_i[WIDTH-1];
            r_quo   <= w_div_zero ? bus.opdata1_i : w_quo_init;
            r_cnt   <= w_div_zero ? '0 : w_cnt_init;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CW'(1);
            r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
            r_rem <= w_trial[WIDTH+1] ? {r_rem[WIDTH-1:0], r_quo[WIDTH-1]} : w_trial[WIDTH:0];
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign bus.busy_o   = r_busy;
    assign bus.dbz_o    = r_dbz;
endmodule

// File: doc/div_iter_param.md
Name: div_iter_param

Overview:
- Parametrised, iterative restoring divider for the EXE stage; successor to the fixed 32-cycle divider.
- Adds the following:
  - WIDTH generalisation
  - per-operation signed/unsigned select
  - a real annul path
  - divide-by-zero flag
  - optional early termination
- EXE holds start_i high while stalled and consumes result_o when ready_o is high.
- result_o feeds the HI/LO write path: high half = remainder (HI), low half = quotient (LO).

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start_i  input  1  request; accepted only in IDLE; held by EXE until ready_o is seen.
- signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- annul_i  input  1  abort the current operation (flush/exception).
- opdata1_i  input  WIDTH  dividend; sampled at accept.
- opdata2_i  input  WIDTH  divisor; sampled at accept.
- result_o  output  2*WIDTH  {remainder, quotient}; valid while ready_o = 1.
- ready_o  output  1  result valid.
- busy_o  output  1  high in DBZ, CALC and FIX.
- dbz_o  output  1  divisor was zero; valid with ready_o.

Behaviour:
- Reset (rst = 0 at an edge), in any state including mid-operation:
  - state → IDLE
  - result_o = 0, ready_o = 0, busy_o = 0, dbz_o = 0
  - iteration counter and operand registers cleared.
- States: IDLE, DBZ, CALC, FIX, DONE.
- IDLE:
  - start_i = 1 and annul_i = 0 → latch operands and signed_i.
  - Divisor == 0 → DBZ; otherwise → CALC.
  - Signed mode latches absolute values and records the two sign bits.
  - ready_o = 0.
- DBZ (1 cycle) → DONE:
  - result = {dividend as latched raw, all-ones}
  - dbz_o = 1.
- CALC: one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits.
  - Each cycle: trial-subtract |divisor|; keep the difference if non-negative.
  - Counter runs WIDTH cycles, then → FIX.
- FIX (1 cycle), signed mode only (unsigned mode passes straight through):
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Negation is two's complement, truncated to WIDTH.
  - Most-negative ÷ −1: quotient = most-negative (wraps), remainder = 0, no flag.
  - Then → DONE.
- DONE:
  - ready_o = 1; result_o and dbz_o stable.
  - Stays in DONE while start_i = 1.
  - When start_i = 0 at an edge → IDLE; ready_o = 0 and dbz_o = 0 from the next cycle.
  - result_o holds its last value in IDLE.
- Latency, with accept at edge k:
  - ready_o high after edge k + WIDTH + 2 (34 edges for WIDTH = 32).
  - Divide-by-zero: ready_o high after edge k + 2.
- start_i dropping during DBZ/CALC/FIX does not abort the operation; DONE then lasts exactly one cycle.
- start_i is ignored outside IDLE; operands are never re-sampled mid-operation.
- annul_i = 1 in DBZ, CALC, FIX or DONE → IDLE at that edge:
  - ready_o = 0, busy_o = 0, dbz_o = 0 next cycle.
  - annul_i has priority over start_i and over completion.
- annul_i = 1 in IDLE blocks acceptance that cycle.
- Simultaneous annul_i and start_i in DONE → IDLE; a new request is accepted on a later edge only.

Optional Feature:
- Macro: DIV_EARLY_TERM_EN.
- Defined:
  - At accept, count leading zeros lz of |dividend|.
  - Pre-shift the dividend by lz and load the counter with WIDTH − lz.
  - Dividend 0 is treated as lz = WIDTH − 1.
  - Latency = (WIDTH − lz) + 2 edges; results are bit-identical to the undefined case.
- Undefined: fixed WIDTH-cycle CALC; no leading-zero logic synthesised.

Test Plan:
- Unsigned 100 ÷ 7, start_i held:
  - result_o = {0x00000002, 0x0000000E}, dbz_o = 0.
  - ready_o first high after edge k+34; without the macro, busy_o is high for 33 cycles.
- Signed −7 ÷ 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0x00000000.
- Divisor 0, dividend 0x12345678:
  - ready_o high after edge k+2, dbz_o = 1.
  - result_o = {0x12345678, 0xFFFFFFFF}.
  - start_i dropped → ready_o = 0 next cycle.
- Start 1000 ÷ 3, annul_i pulsed on the 10th CALC cycle:
  - ready_o never rises; busy_o = 0 next cycle.
  - New request 9 ÷ 3 → {0, 3} after 34 edges.
- rst = 0 on the 5th CALC cycle:
  - all outputs 0 next cycle; start_i ignored while rst = 0.
  - With DIV_EARLY_TERM_EN, 5 ÷ 1 → {0, 5}, ready_o after edge k+5.
